// File: rtl/pacman_pkg.sv
// Shared encodings and default playfield limits for the Pac-Man game controller.
package pacman_pkg;

  typedef enum logic [1:0] {
    SCR_TITLE     = 2'd0,
    SCR_PLAY      = 2'd1,
    SCR_DYING     = 2'd2,
    SCR_GAME_OVER = 2'd3
  } screen_e;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  localparam int X_W         = 8;
  localparam int Y_W         = 7;
  localparam int X_MAX_DEF   = 159;
  localparam int Y_MAX_DEF   = 119;
  localparam int X_START_DEF = 80;
  localparam int Y_START_DEF = 60;

endpackage

// File: rtl/pacman_pos_unit.sv
// Pac-Man position register: one-pixel steps with toroidal wrap, reloadable to spawn.
module pacman_pos_unit
  import pacman_pkg::*;
#(
  parameter int X_MAX   = X_MAX_DEF,
  parameter int Y_MAX   = Y_MAX_DEF,
  parameter int X_START = X_START_DEF,
  parameter int Y_START = Y_START_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_spawn_i,
  input  logic           move_en_i,
  input  logic [1:0]     dir_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_spawn_i) begin
      x_d = X_W'(X_START);
      y_d = Y_W'(Y_START);
    end else if (move_en_i) begin
      // Screen coordinates: "up" lowers y.
      case (dir_e'(dir_i))
        DIR_RIGHT: x_d = (x_q == X_W'(X_MAX)) ? '0 : x_q + 1'b1;
        DIR_LEFT:  x_d = (x_q == '0) ? X_W'(X_MAX) : x_q - 1'b1;
        DIR_UP:    y_d = (y_q == '0) ? Y_W'(Y_MAX) : y_q - 1'b1;
        DIR_DOWN:  y_d = (y_q == Y_W'(Y_MAX)) ? '0 : y_q + 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= X_W'(X_START);
      y_q <= Y_W'(Y_START);
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/pacman_game_ctrl.sv
// Pac-Man game controller: screen FSM, score, lives, power and death timers.
module pacman_game_ctrl
  import pacman_pkg::*;
#(
  parameter int NUM_GHOSTS   = 4,
  parameter int LIVES        = 3,
  parameter int SCORE_W      = 8,
  parameter int GHOST_PTS    = 10,
  parameter int POWER_CYCLES = 200,
  parameter int DEATH_CYCLES = 50,
  parameter int X_MAX        = X_MAX_DEF,
  parameter int Y_MAX        = Y_MAX_DEF,
  parameter int X_START      = X_START_DEF,
  parameter int Y_START      = Y_START_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         startGame,
  input  logic [1:0]                   direction,
  input  logic                         moveTick,
  input  logic                         touchingWall,
  input  logic                         pellet,
  input  logic                         powerPellet,
  input  logic [NUM_GHOSTS-1:0]        touchingGhost,
  input  logic [NUM_GHOSTS-1:0]        badGhost,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [1:0]                   s_screen,
  output logic [SCORE_W-1:0]           score,
  output logic [$clog2(LIVES+1)-1:0]   lives,
  output logic                         power_active,
  output logic [NUM_GHOSTS-1:0]        ghost_eaten,
  output logic                         en_ghostRand,
  output logic                         move_index,
  output logic                         s_game_over
);

  localparam int LW = $clog2(LIVES + 1);
  localparam int PW = $clog2(POWER_CYCLES + 1);
  localparam int DW = $clog2(DEATH_CYCLES + 1);
  localparam int CW = $clog2(NUM_GHOSTS + 1);
  localparam int SW = SCORE_W + 8;

  screen_e                state_q, state_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [LW-1:0]          lives_q, lives_d;
  logic [PW-1:0]          power_q, power_d;
  logic [DW-1:0]          death_q, death_d;
  logic [NUM_GHOSTS-1:0]  eaten_q, eaten_d;
  logic                   mi_q, mi_d;
  logic                   start_prev_q;
  logic                   start_armed_q;

  logic                   start_rise;
  logic                   load_spawn;
  logic                   move_en;
  logic [NUM_GHOSTS-1:0]  lethal_vec;
  logic [NUM_GHOSTS-1:0]  eat_vec;
  logic [CW-1:0]          eat_cnt;
  logic [SW-1:0]          sum_w;

  // A rising edge only counts once startGame has been seen low after reset,
  // so a button held through reset release cannot launch a game.
  assign start_rise = startGame & ~start_prev_q & start_armed_q;

  assign lethal_vec = touchingGhost & badGhost & {NUM_GHOSTS{~power_active}};
  assign eat_vec    = touchingGhost & {NUM_GHOSTS{power_active}};

  always_comb begin
    eat_cnt = '0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      eat_cnt = eat_cnt + CW'(eat_vec[i]);
    end
    sum_w = SW'(score_q) + SW'(pellet) + SW'(GHOST_PTS) * SW'(eat_cnt);
  end

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    lives_d    = lives_q;
    power_d    = power_q;
    death_d    = death_q;
    eaten_d    = '0;
    mi_d       = mi_q;
    load_spawn = 1'b0;
    move_en    = 1'b0;
    case (state_q)
      SCR_TITLE: begin
        if (start_rise) begin
          state_d    = SCR_PLAY;
          score_d    = '0;
          lives_d    = LW'(LIVES);
          power_d    = '0;
          load_spawn = 1'b1;
        end
      end
      SCR_PLAY: begin
        if (moveTick) mi_d = ~mi_q;
        if (|lethal_vec) begin
          // Death swallows every other event of the same cycle.
          state_d = SCR_DYING;
          lives_d = (lives_q != '0) ? lives_q - 1'b1 : '0;
          power_d = '0;
          death_d = DW'(DEATH_CYCLES - 1);
        end else begin
          move_en = moveTick & ~touchingWall;
          eaten_d = eat_vec;
          score_d = (|sum_w[SW-1:SCORE_W]) ? '1 : sum_w[SCORE_W-1:0];
          if (powerPellet)          power_d = PW'(POWER_CYCLES);
          else if (power_q != '0)   power_d = power_q - 1'b1;
        end
      end
      SCR_DYING: begin
        if (death_q == '0) begin
          if (lives_q == '0) begin
            state_d = SCR_GAME_OVER;
          end else begin
            state_d    = SCR_PLAY;
            load_spawn = 1'b1;
          end
        end else begin
          death_d = death_q - 1'b1;
        end
      end
      SCR_GAME_OVER: begin
        if (start_rise) state_d = SCR_TITLE;
      end
      default: state_d = SCR_TITLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SCR_TITLE;
      score_q       <= '0;
      lives_q       <= LW'(LIVES);
      power_q       <= '0;
      death_q       <= '0;
      eaten_q       <= '0;
      mi_q          <= 1'b0;
      start_prev_q  <= 1'b0;
      start_armed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      power_q       <= power_d;
      death_q       <= death_d;
      eaten_q       <= eaten_d;
      mi_q          <= mi_d;
      start_prev_q  <= startGame;
      start_armed_q <= start_armed_q | ~startGame;
    end
  end

  pacman_pos_unit #(
    .X_MAX   (X_MAX),
    .Y_MAX   (Y_MAX),
    .X_START (X_START),
    .Y_START (Y_START)
  ) u_pos (
    .clk          (clk),
    .rst_n        (reset),
    .load_spawn_i (load_spawn),
    .move_en_i    (move_en),
    .dir_i        (direction),
    .x_o          (x),
    .y_o          (y)
  );

  assign s_screen     = state_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign power_active = (power_q != '0);
  assign ghost_eaten  = eaten_q;
  assign en_ghostRand = (state_q == SCR_PLAY);
  assign move_index   = mi_q;
  assign s_game_over  = (state_q == SCR_GAME_OVER);

endmodule

// File: tb/tb_pacman_game_ctrl.sv
// Directed bench for pacman_game_ctrl with hand-computed expectations.
module tb_pacman_game_ctrl;

  logic       clk;
  logic       reset;
  logic       startGame;
  logic [1:0] direction;
  logic       moveTick;
  logic       touchingWall;
  logic       pellet;
  logic       powerPellet;
  logic [3:0] touchingGhost;
  logic [3:0] badGhost;
  logic [7:0] x;
  logic [6:0] y;
  logic [1:0] s_screen;
  logic [7:0] score;
  logic [1:0] lives;
  logic       power_active;
  logic [3:0] ghost_eaten;
  logic       en_ghostRand;
  logic       move_index;
  logic       s_game_over;

  int checks   = 0;
  int failures = 0;

  pacman_game_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .startGame     (startGame),
    .direction     (direction),
    .moveTick      (moveTick),
    .touchingWall  (touchingWall),
    .pellet        (pellet),
    .powerPellet   (powerPellet),
    .touchingGhost (touchingGhost),
    .badGhost      (badGhost),
    .x             (x),
    .y             (y),
    .s_screen      (s_screen),
    .score         (score),
    .lives         (lives),
    .power_active  (power_active),
    .ghost_eaten   (ghost_eaten),
    .en_ghostRand  (en_ghostRand),
    .move_index    (move_index),
    .s_game_over   (s_game_over)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; startGame = 1'b1; direction = 2'd0; moveTick = 1'b0;
    touchingWall = 1'b0; pellet = 1'b0; powerPellet = 1'b0;
    touchingGhost = 4'b0; badGhost = 4'b0;
    steps(2);
    check("rst_screen", s_screen, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives, 3);
    check("rst_x", x, 80);
    check("rst_y", y, 60);
    check("rst_power", power_active, 0);
    check("rst_eaten", ghost_eaten, 0);
    check("rst_en", en_ghostRand, 0);
    check("rst_mi", move_index, 0);
    check("rst_go", s_game_over, 0);

    // startGame held through release must not start a game
    reset = 1'b1;
    steps(3);
    check("held_start_title", s_screen, 0);
    startGame = 1'b0; step();
    startGame = 1'b1; step();
    check("start_screen", s_screen, 1);
    check("start_score", score, 0);
    check("start_lives", lives, 3);
    check("start_x", x, 80);
    check("start_y", y, 60);
    check("start_en", en_ghostRand, 1);

    // Movement and wrap
    direction = 2'd0; moveTick = 1'b1; step();
    check("move_r_x", x, 81);
    check("move_r_mi", move_index, 1);
    steps(78);
    check("move_to_max", x, 159);
    step();
    check("wrap_x_max", x, 0);
    check("wrap_mi", move_index, 0);
    touchingWall = 1'b1; step();
    check("wall_x", x, 0);
    check("wall_mi", move_index, 1);
    touchingWall = 1'b0;
    direction = 2'd1; step();
    check("wrap_x_zero", x, 159);
    direction = 2'd2; step();
    check("up_y", y, 59);
    check("up_x", x, 159);
    direction = 2'd3; step();
    check("down_y", y, 60);
    moveTick = 1'b0;

    // Pellet and power mode
    pellet = 1'b1; step(); pellet = 1'b0;
    check("pellet_score", score, 1);
    powerPellet = 1'b1; step(); powerPellet = 1'b0;
    check("power_on", power_active, 1);
    touchingGhost = 4'b0011; badGhost = 4'b0011; step();
    check("eat_vec", ghost_eaten, 4'b0011);
    check("eat_score", score, 21);
    check("eat_no_death", s_screen, 1);
    touchingGhost = 4'b0; badGhost = 4'b0; step();
    check("eat_pulse_end", ghost_eaten, 0);
    steps(197);
    check("power_last", power_active, 1);
    step();
    check("power_off", power_active, 0);

    // Harmless ghost without power
    touchingGhost = 4'b0100; step(); touchingGhost = 4'b0;
    check("nonbad_screen", s_screen, 1);
    check("nonbad_lives", lives, 3);
    check("nonbad_eaten", ghost_eaten, 0);

    // Lethal collision with simultaneous pellet
    touchingGhost = 4'b0100; badGhost = 4'b0100; pellet = 1'b1; step();
    touchingGhost = 4'b0; badGhost = 4'b0;
    check("die_screen", s_screen, 2);
    check("die_lives", lives, 2);
    check("die_score", score, 21);
    check("die_en", en_ghostRand, 0);
    moveTick = 1'b1;
    steps(48);
    pellet = 1'b0; moveTick = 1'b0;
    step();
    check("dying_dwell", s_screen, 2);
    check("dying_score", score, 21);
    step();
    check("respawn_screen", s_screen, 1);
    check("respawn_x", x, 80);
    check("respawn_y", y, 60);
    check("respawn_score", score, 21);

    // Score saturation
    pellet = 1'b1; steps(229); pellet = 1'b0;
    check("score_250", score, 250);
    powerPellet = 1'b1; step(); powerPellet = 1'b0;
    touchingGhost = 4'b0011; step(); touchingGhost = 4'b0;
    check("sat_score", score, 255);
    check("sat_eaten", ghost_eaten, 4'b0011);
    pellet = 1'b1; step(); pellet = 1'b0;
    check("sat_pellet", score, 255);
    steps(198);
    check("power_off2", power_active, 0);

    // Two more deaths to game over
    touchingGhost = 4'b0001; badGhost = 4'b0001; step();
    touchingGhost = 4'b0; badGhost = 4'b0;
    check("die2_lives", lives, 1);
    steps(50);
    check("die2_back", s_screen, 1);
    touchingGhost = 4'b1000; badGhost = 4'b1000; step();
    touchingGhost = 4'b0; badGhost = 4'b0;
    check("die3_lives", lives, 0);
    steps(50);
    check("go_screen", s_screen, 3);
    check("go_flag", s_game_over, 1);
    check("go_en", en_ghostRand, 0);
    pellet = 1'b1; step(); pellet = 1'b0;
    check("go_score_frozen", score, 255);
    startGame = 1'b0; step();
    startGame = 1'b1; step();
    check("go_to_title", s_screen, 0);
    startGame = 1'b0; step();
    startGame = 1'b1; step();
    check("restart_screen", s_screen, 1);
    check("restart_score", score, 0);
    check("restart_lives", lives, 3);
    startGame = 1'b0;

    // Asynchronous reset mid-game
    direction = 2'd0; moveTick = 1'b1; step(); moveTick = 1'b0;
    check("pre_reset_x", x, 81);
    #2 reset = 1'b0;
    #1;
    check("async_screen", s_screen, 0);
    check("async_x", x, 80);
    check("async_lives", lives, 3);
    step();
    reset = 1'b1;
    steps(2);
    check("post_reset_title", s_screen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pacman_game_ctrl.md
PACMAN_GAME_CTRL -- requirements
Module: pacman_game_ctrl

Interface
REQ-001 Parameter NUM_GHOSTS, 4, number of independent ghost collision channels.
REQ-002 Parameter LIVES, 3, lives granted at game start.
REQ-003 Parameter SCORE_W, 8, score width in bits.
REQ-004 Parameter GHOST_PTS, 10, points per eaten ghost.
REQ-005 Parameter POWER_CYCLES, 200, power-mode duration in clk cycles.
REQ-006 Parameter DEATH_CYCLES, 50, DYING dwell time in clk cycles.
REQ-007 Parameters X_MAX, 159; Y_MAX, 119; X_START, 80; Y_START, 60: playfield limits and spawn point.
REQ-008 clk  in  1  single system clock, rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-010 startGame  in  1  start/restart request, rising edge acted on.
REQ-011 direction  in  2  0 right, 1 left, 2 up, 3 down.
REQ-012 moveTick  in  1  one-cycle movement strobe.
REQ-013 touchingWall  in  1  blocks the pending move.
REQ-014 pellet / powerPellet  in  1 each  one-cycle pellet-eaten strobes.
REQ-015 touchingGhost  in  NUM_GHOSTS  per-ghost collision.
REQ-016 badGhost  in  NUM_GHOSTS  per-ghost lethal flag.
REQ-017 x  out  8 / y  out  7  Pac-Man position.
REQ-018 s_screen  out  2  0 TITLE, 1 PLAY, 2 DYING, 3 GAME_OVER.
REQ-019 score  out  SCORE_W; lives  out  $clog2(LIVES+1); power_active  out  1; ghost_eaten  out  NUM_GHOSTS; en_ghostRand, move_index, s_game_over  out  1 each.

Function
REQ-020 All outputs registered; every effect visible the cycle after the causing input.
REQ-021 TITLE -> PLAY on startGame rising edge (registered previous value); entry loads score=0, lives=LIVES, x/y=spawn, power cleared.
REQ-022 In PLAY, moveTick with touchingWall=0 moves one pixel per direction; x wraps X_MAX->0 and 0->X_MAX, y likewise with Y_MAX; touchingWall=1 holds position.
REQ-023 move_index toggles on every moveTick in PLAY; en_ghostRand=1 only in PLAY.
REQ-024 pellet adds 1 to score; saturates at 2^SCORE_W-1, never wraps.
REQ-025 powerPellet in PLAY loads timer=POWER_CYCLES (restart, no accumulation); timer decrements each cycle; power_active = (timer!=0).
REQ-026 Ghost i is lethal when touchingGhost[i] & badGhost[i] & !power_active; any lethal ghost -> DYING, lives-1, power cleared; all same-cycle pellet/score events discarded.
REQ-027 With power_active, each touching ghost i pulses ghost_eaten[i] for one cycle; score += GHOST_PTS x (eaten count), saturating; pellet in same cycle also added.
REQ-028 Touching non-bad ghost without power: no effect.
REQ-029 DYING dwells DEATH_CYCLES cycles, then -> GAME_OVER if lives==0, else -> PLAY with x/y=spawn, score kept.
REQ-030 GAME_OVER: s_game_over=1, score frozen; startGame rising edge -> TITLE.
REQ-031 Inputs other than startGame ignored outside PLAY; startGame ignored in PLAY/DYING.

Reset
REQ-032 Reset (asserted low) asynchronously forces: s_screen=TITLE, score=0, lives=LIVES, x=X_START, y=Y_START, timers=0, power_active=0, ghost_eaten=0, en_ghostRand=0, move_index=0, s_game_over=0, startGame edge register=0.
REQ-033 Reset mid-game abandons all state; startGame held high through reset release does not start a game without a new rising edge.

Structure
REQ-034 Screen encodings, direction encodings and default limits live in shared package pacman_pkg.
REQ-035 Position register with wrap logic is sub-module pacman_pos_unit; FSM, score, lives, timers stay in the top.

Verification
REQ-036 Reset, startGame 0->1 -> s_screen=1, score=0, lives=3, x=80, y=60, en_ghostRand=1.
REQ-037 x=159, direction=0, moveTick -> x=0; touchingWall=1 with moveTick -> x unchanged, move_index still toggles.
REQ-038 powerPellet, then touchingGhost=4'b0011, badGhost=4'b0011 -> ghost_eaten=4'b0011 one cycle, score +20, no death; after 200 cycles power_active=0.
REQ-039 No power, touchingGhost[2]=1, badGhost[2]=1, pellet=1 same cycle -> s_screen=2, lives=2, score unchanged; after 50 cycles s_screen=1, x=80.
REQ-040 Three lethal collisions -> s_screen=3, s_game_over=1; startGame rising edge -> s_screen=0.
REQ-041 Score 250, two ghosts eaten in power mode -> score=255 (saturated).
